cmd_fetch: RTL and testbench
============================

// Module: cmd_fetch
// PURPOSE
//  Command-stream reader for the async instruction memory. Walks the memory via its two
//  async read ports (addr1 -> read0, addr2 -> read1..read4) and parses headers
//  (bit31 = payload, [15:8] = payload word count, [7:0] = opcode). Emits each command to
//  the geometry/raster pipeline as 1..N ready/valid beats of up to 4 words. Executes
//  flush (0x05), jump (0x06) and nop (0x00) itself.
// PARAMETERS
//  ADDR_W      10  program-counter width; pc/ptr wrap modulo 2**ADDR_W
//  START_ADDR  0   pc value after reset
// PORTS
//  clk        in   1    clock
//  rst        in   1    synchronous reset, active high
//  run        in   1    1 = fetch; 0 = stop at next header boundary
//  addr1      out  32   header address {zero-ext, pc}
//  addr2      out  32   operand base address {zero-ext, ptr}
//  read0      in   32   mem[addr1], combinational
//  read1..4   in   32   mem[addr2+0..3], combinational
//  out_valid  out  1    beat valid
//  out_ready  in   1    downstream accepts beat
//  out_op     out  8    opcode of command carrying this beat
//  out_data   out  128  {w0,w1,w2,w3}; w0 in [127:96]; unused words zero
//  out_nwords out  3    valid words in beat, 0..4
//  out_first  out  1    first beat of command
//  out_last   out  1    last beat of command
//  busy       out  1    state != IDLE && state != HALT
//  err        out  1    sticky: undecodable header seen
// BEHAVIOUR
//  Reset: pc=START_ADDR, ptr=0, state=IDLE, out_valid=0, out_op/data/nwords/first/last=0,
//   busy=0, err=0. Applies in any state, including mid-payload; an in-flight beat is dropped.
//  All out_* are registered. Beat register loads when (!out_valid || out_ready); it holds
//   stable while out_valid && !out_ready. No beat is lost or duplicated.
//  States:
//   IDLE: run=1 -> HDR.
//   HDR:  addr1=pc, addr2=pc+1. Decode read0 in one cycle:
//    - bit31=1, len>0: latch op, rem=len, ptr=pc+1, first_pend=1 -> PAY.
//    - bit31=1, len=0, or opcode 0x05 (flush): when beat reg free, load op,
//      nwords=0, data=0, first=last=1; pc+=1. Stay in HDR (stalls while reg busy).
//    - opcode 0x06 (jump): pc <= read1[ADDR_W-1:0]; no beat; 1 cycle. Jump-to-self spins.
//    - opcode 0x00 (nop): pc+=1.
//    - bit31=0, any other opcode: err=1 -> HALT; no beat.
//    - run=0 at HDR entry: -> IDLE, pc held.
//   PAY:  addr2=ptr. When beat reg free: n=min(rem,4); load data from read1..read(n),
//    zero the rest; nwords=n; first=first_pend; last=(rem<=4); ptr+=n; rem-=n;
//    first_pend=0. If last: pc <= ptr+n -> HDR.
//   HALT: terminal until rst. Already-loaded beat still drains.
//  Latency: header sampled at cycle N -> first payload beat out_valid at N+2 with
//   out_ready=1 (HDR cycle, PAY load cycle); back-to-back beats 1/cycle thereafter.
//  Widths: len 8 bits (max 255 words); pc/ptr arithmetic modulo 2**ADDR_W, payload crossing
//   top address wraps to 0. Memory writes via the BRAM port during fetch are not
//   synchronised; already-loaded beats are unaffected.
// TESTING
//  1. mem[0]=80000304,3F800000,0,0; run=1 -> 1 beat op=04 nwords=3
//     data={3F800000,0,0,0} first=last=1; next header at pc=4.
//  2. 80001016 + 16 words -> 4 beats nwords=4, first on beat0 only, last on beat3;
//     words in order; pc=17 after.
//  3. Same matrix, out_ready=0 for 5 cycles at beat1 -> beat1 held bit-exact;
//     16 words delivered once each.
//  4. mem[41]=5, mem[42]=6, mem[43]=0 -> flush beat op=05 nwords=0 first=last=1;
//     then pc=0; stream replays from mem[0].
//  5. Header 00000077 -> err=1, HALT, busy=0, no beat; rst -> err=0, pc=START_ADDR.
//  6. rst asserted during beat2 of matrix -> next cycle out_valid=0, state IDLE;
//     run=1 restarts at START_ADDR.

Source files
------------

// File: rtl/cmd_fetch.sv
// cmd_fetch: walks the instruction memory, parses command headers and streams payload beats downstream.
module cmd_fetch #(
  parameter int ADDR_W = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  output logic [31:0]  addr1,
  output logic [31:0]  addr2,
  input  logic [31:0]  read0,
  input  logic [31:0]  read1,
  input  logic [31:0]  read2,
  input  logic [31:0]  read3,
  input  logic [31:0]  read4,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_op,
  output logic [127:0] out_data,
  output logic [2:0]   out_nwords,
  output logic         out_first,
  output logic         out_last,
  output logic         busy,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, HDR, PAY, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ptr_q, ptr_d;
  logic [7:0] rem_q, rem_d, op_q, op_d;
  logic first_pend_q, first_pend_d, err_q, err_d;
  logic out_valid_q, out_valid_d, out_first_q, out_first_d, out_last_q, out_last_d;
  logic [7:0] out_op_q, out_op_d;
  logic [127:0] out_data_q, out_data_d;
  logic [2:0] out_nwords_q, out_nwords_d;
  logic free;
  logic [2:0] n;
  logic [7:0] len, opc;
  assign free = !out_valid_q || out_ready;
  assign n = (rem_q >= 8'd4) ? 3'd4 : rem_q[2:0];
  assign len = read0[15:8];
  assign opc = read0[7:0];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ptr_d = ptr_q;
    rem_d = rem_q;
    op_d = op_q;
    first_pend_d = first_pend_q;
    err_d = err_q;
    out_valid_d = out_valid_q && !out_ready;
    out_op_d = out_op_q;
    out_data_d = out_data_q;
    out_nwords_d = out_nwords_q;
    out_first_d = out_first_q;
    out_last_d = out_last_q;
    case (state_q)
      IDLE: state_d = run ? HDR : IDLE;
      HDR: begin
        if (!run) state_d = IDLE;
        else if (read0[31] && len != 8'd0) begin
          op_d = opc;
          rem_d = len;
          ptr_d = pc_q + 1'b1;
          first_pend_d = 1'b1;
          state_d = PAY;
        end else if (read0[31] || opc == 8'h05) begin
          // Empty commands still emit one zero-word beat so downstream sees them
          if (free) begin
            out_valid_d = 1'b1;
            out_op_d = opc;
            out_data_d = '0;
            out_nwords_d = 3'd0;
            out_first_d = 1'b1;
            out_last_d = 1'b1;
            pc_d = pc_q + 1'b1;
          end
        end else if (opc == 8'h06) pc_d = read1[ADDR_W-1:0];
        else if (opc == 8'h00) pc_d = pc_q + 1'b1;
        else begin
          err_d = 1'b1;
          state_d = HALT;
        end
      end
      PAY: begin
        if (free) begin
          out_valid_d = 1'b1;
          out_op_d = op_q;
          out_data_d = {read1, n > 3'd1 ? read2 : 32'd0, n > 3'd2 ? read3 : 32'd0,
                        n > 3'd3 ? read4 : 32'd0};
          out_nwords_d = n;
          out_first_d = first_pend_q;
          out_last_d = rem_q <= 8'd4;
          ptr_d = ptr_q + ADDR_W'(n);
          rem_d = rem_q - 8'(n);
          first_pend_d = 1'b0;
          if (rem_q <= 8'd4) begin
            pc_d = ptr_q + ADDR_W'(n);
            state_d = HDR;
          end
        end
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= ADDR_W'(START_ADDR);
      ptr_q <= '0;
      rem_q <= '0;
      op_q <= '0;
      first_pend_q <= 1'b0;
      err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_op_q <= '0;
      out_data_q <= '0;
      out_nwords_q <= '0;
      out_first_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      op_q <= op_d;
      first_pend_q <= first_pend_d;
      err_q <= err_d;
      out_valid_q <= out_valid_d;
      out_op_q <= out_op_d;
      out_data_q <= out_data_d;
      out_nwords_q <= out_nwords_d;
      out_first_q <= out_first_d;
      out_last_q <= out_last_d;
    end
  end
  assign addr1 = 32'(pc_q);
  assign addr2 = 32'(state_q == PAY ? ptr_q : pc_q + 1'b1);
  assign out_valid = out_valid_q;
  assign out_op = out_op_q;
  assign out_data = out_data_q;
  assign out_nwords = out_nwords_q;
  assign out_first = out_first_q;
  assign out_last = out_last_q;
  assign busy = state_q != IDLE && state_q != HALT;
  assign err = err_q;
endmodule

// File: tb/tb_cmd_fetch.sv
// tb_cmd_fetch: directed checks of header decode, payload beats, backpressure, flush/jump, error and reset.
module tb_cmd_fetch;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, out_ready = 1'b1;
  logic [31:0] addr1, addr2, read0, read1, read2, read3, read4;
  logic out_valid, out_first, out_last, busy, err;
  logic [7:0] out_op;
  logic [127:0] out_data;
  logic [2:0] out_nwords;
  logic [31:0] mem [0:1023];
  logic [9:0] a1, a2;
  int n_chk = 0, n_pass = 0, nb = 0;
  logic [7:0] b_op [64];
  logic [127:0] b_data [64];
  logic [2:0] b_nw [64];
  logic b_first [64], b_last [64];
  cmd_fetch dut (
    .clk(clk), .rst(rst), .run(run), .addr1(addr1), .addr2(addr2),
    .read0(read0), .read1(read1), .read2(read2), .read3(read3), .read4(read4),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_data(out_data),
    .out_nwords(out_nwords), .out_first(out_first), .out_last(out_last),
    .busy(busy), .err(err)
  );
  assign a1 = addr1[9:0];
  assign a2 = addr2[9:0];
  assign read0 = mem[a1];
  assign read1 = mem[a2];
  assign read2 = mem[a2 + 10'd1];
  assign read3 = mem[a2 + 10'd2];
  assign read4 = mem[a2 + 10'd3];
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && out_valid && out_ready && nb < 64) begin
      b_op[nb] = out_op;
      b_data[nb] = out_data;
      b_nw[nb] = out_nwords;
      b_first[nb] = out_first;
      b_last[nb] = out_last;
      nb = nb + 1;
    end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    out_ready = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask
  task automatic wait_beats(input int n, input string tag);
    int t = 0;
    while (nb < n && t < 300) begin
      cyc(1);
      t++;
    end
    chk(tag, 128'(nb >= n), 128'd1);
  endtask
  function automatic logic [31:0] mx(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0101;
  endfunction
  function automatic logic [127:0] mrow(input int k);
    return {mx(4 * k), mx(4 * k + 1), mx(4 * k + 2), mx(4 * k + 3)};
  endfunction
  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask
  task automatic load_matrix();
    clear_mem();
    mem[0] = 32'h8000_1016;
    for (int i = 0; i < 16; i++) mem[1 + i] = mx(i);
    mem[17] = 32'h0000_0006;
    mem[18] = 32'd17;
  endtask
  task automatic check_matrix(input int base, input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_op%0d", tag, k), 128'(b_op[base + k]), 128'h16);
      chk($sformatf("%s_data%0d", tag, k), b_data[base + k], mrow(k));
      chk($sformatf("%s_nw%0d", tag, k), 128'(b_nw[base + k]), 128'd4);
      chk($sformatf("%s_first%0d", tag, k), 128'(b_first[base + k]), 128'(k == 0));
      chk($sformatf("%s_last%0d", tag, k), 128'(b_last[base + k]), 128'(k == 3));
    end
  endtask
  initial begin
    int base;
    clear_mem();
    do_reset();
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_op", 128'(out_op), 128'd0);
    chk("rst_data", out_data, 128'd0);
    chk("rst_nw", 128'(out_nwords), 128'd0);
    chk("rst_first_last", 128'({out_first, out_last}), 128'd0);
    chk("rst_busy_err", 128'({busy, err}), 128'd0);
    chk("rst_pc", 128'(addr1), 128'd0);
    mem[0] = 32'h8000_0304;
    mem[1] = 32'h3F80_0000;
    mem[4] = 32'h0000_0006;
    mem[5] = 32'd4;
    base = nb;
    run = 1'b1;
    wait_beats(base + 1, "t1_wait");
    cyc(4);
    chk("t1_count", 128'(nb - base), 128'd1);
    chk("t1_op", 128'(b_op[base]), 128'h04);
    chk("t1_nw", 128'(b_nw[base]), 128'd3);
    chk("t1_data", b_data[base], {32'h3F80_0000, 96'd0});
    chk("t1_first_last", 128'({b_first[base], b_last[base]}), 128'b11);
    chk("t1_pc", 128'(addr1), 128'd4);
    chk("t1_busy", 128'(busy), 128'd1);
    do_reset();
    load_matrix();
    base = nb;
    run = 1'b1;
    wait_beats(base + 4, "t2_wait");
    cyc(5);
    chk("t2_count", 128'(nb - base), 128'd4);
    check_matrix(base, "t2");
    chk("t2_pc", 128'(addr1), 128'd17);
    do_reset();
    base = nb;
    run = 1'b1;
    wait_beats(base + 1, "t3_wait1");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk($sformatf("t3_hold_data%0d", i), out_data, mrow(1));
      chk($sformatf("t3_hold_ctl%0d", i), 128'({out_valid, out_first, out_last, out_nwords}), 128'b1_0_0_100);
    end
    out_ready = 1'b1;
    wait_beats(base + 4, "t3_wait4");
    cyc(8);
    chk("t3_count", 128'(nb - base), 128'd4);
    check_matrix(base, "t3");
    do_reset();
    clear_mem();
    mem[0] = 32'h8000_0104;
    mem[1] = 32'hDEAD_BEEF;
    mem[2] = 32'h0000_0006;
    mem[3] = 32'd41;
    mem[41] = 32'h0000_0005;
    mem[42] = 32'h0000_0006;
    mem[43] = 32'd0;
    base = nb;
    run = 1'b1;
    wait_beats(base + 3, "t4_wait");
    chk("t4_b0", {b_op[base], b_nw[base], b_data[base][127:96]}, {8'h04, 3'd1, 32'hDEAD_BEEF});
    chk("t4_flush_op", 128'(b_op[base + 1]), 128'h05);
    chk("t4_flush_nw", 128'(b_nw[base + 1]), 128'd0);
    chk("t4_flush_data", b_data[base + 1], 128'd0);
    chk("t4_flush_fl", 128'({b_first[base + 1], b_last[base + 1]}), 128'b11);
    chk("t4_replay", {b_op[base + 2], b_data[base + 2]}, {8'h04, 32'hDEAD_BEEF, 96'd0});
    do_reset();
    clear_mem();
    mem[0] = 32'h0000_0077;
    base = nb;
    run = 1'b1;
    cyc(6);
    chk("t5_err", 128'(err), 128'd1);
    chk("t5_busy", 128'(busy), 128'd0);
    chk("t5_nobeat", 128'({out_valid, 32'(nb - base)}), 128'd0);
    do_reset();
    chk("t5_rst_err", 128'(err), 128'd0);
    chk("t5_rst_pc", 128'(addr1), 128'd0);
    load_matrix();
    base = nb;
    run = 1'b1;
    wait_beats(base + 2, "t6_wait2");
    rst = 1'b1;
    cyc(1);
    chk("t6_valid", 128'(out_valid), 128'd0);
    chk("t6_idle", 128'(busy), 128'd0);
    chk("t6_pc", 128'(addr1), 128'd0);
    rst = 1'b0;
    base = nb;
    wait_beats(base + 4, "t6_wait4");
    cyc(5);
    chk("t6_count", 128'(nb - base), 128'd4);
    check_matrix(base, "t6");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
